sram_controller: RTL and testbench

Sequences every data-memory access from the MEM stage onto the external 32-bit asynchronous SRAM. It translates CPU byte addresses into SRAM word addresses and enforces a fixed number of wait cycles per access. It drives the tri-state data bus and produces the `ready` signal that freezes the rest of the pipeline while an access is in flight. It sits inside the memory stage, between the EXE-stage pipeline register outputs and the `SRAM_*` pins of the top level.

---
 rtl/sram_controller_if.sv | 19 +
 rtl/sram_controller.sv | 112 +++++++++++
 tb/tb_sram_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bus between the MEM stage and the SRAM controller.
interface sram_controller_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Fixed-latency access sequencer between the MEM stage and a 32-bit asynchronous SRAM.
// IDLE: accept request | ACCESS: bus driven, wait count running | DONE: one-cycle ready pulse
module sram_controller #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  inout  wire  [31:0]       SRAM_DQ
);

  localparam int CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_is_wr;

  logic             w_req;
  logic             w_accept;
  logic             w_last;
  logic             w_drive;
  logic             w_ready;
  logic [31:0]      w_off;
  logic             w_unused;

  assign w_req  = bus.rd_en | bus.wr_en;
  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b1;
    w_accept = 1'b0;
    w_drive  = 1'b0;
    case (r_state)
      IDLE: begin
        // Combinational so the pipeline freezes in the same cycle it asks.
        w_ready = ~w_req;
        if (w_req) begin
          w_accept = 1'b1;
          w_next   = ACCESS;
        end
      end
      ACCESS: begin
        w_ready = 1'b0;
        w_drive = r_is_wr;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_is_wr <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_addr  <= bus.address;
      r_wdata <= bus.write_data;
      r_is_wr <= bus.wr_en;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last && !r_is_wr) begin
        r_rdata <= SRAM_DQ;
      end
    end
  end

  // Out-of-window addresses simply wrap; the dropped bits are intentionally ignored.
  assign w_off     = r_addr - 32'(BASE_ADDR);
  assign SRAM_ADDR = w_off[ADDR_W+1:2];
  assign w_unused  = ^{w_off[31:ADDR_W+2], w_off[1:0]};

  assign SRAM_WE_N     = ~w_drive;
  assign SRAM_DQ       = w_drive ? r_wdata : 32'bz;
  assign bus.ready     = w_ready;
  assign bus.read_data = r_rdata;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a 4-word SRAM model that drives the bus whenever WE_N is high.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic [16:0] sram_addr;
  logic        sram_we_n;
  wire  [31:0] sram_dq;
  logic        model_init;
  logic [31:0] mem [4];
  int          n_tests;
  int          n_fail;

  sram_controller_if bus_if ();

  sram_controller #(
    .WAIT_CYCLES(5),
    .BASE_ADDR  (1024),
    .ADDR_W     (17)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .SRAM_ADDR(sram_addr),
    .SRAM_WE_N(sram_we_n),
    .SRAM_DQ  (sram_dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM: outputs the addressed word while not writing, so an undriven
  // controller bus reads back the stored word instead of the write data.
  assign sram_dq = sram_we_n ? mem[sram_addr[1:0]] : 32'bz;

  always @(posedge clk) begin
    if (model_init) begin
      mem[0] <= 32'hA0A0A0A0;
      mem[1] <= 32'hB1B1B1B1;
      mem[2] <= 32'hC2C2C2C2;
      mem[3] <= 32'hD3D3D3D3;
    end else if (!sram_we_n) begin
      mem[sram_addr[1:0]] <= sram_dq;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request in the current cycle and follows it to DONE, checking every ACCESS cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_addr,
                        input logic [31:0] exp_dq, input string tag);
    int stall;
    stall = 0;
    bus_if.rd_en      = rd;
    bus_if.wr_en      = wr;
    bus_if.address    = a;
    bus_if.write_data = d;
    #1;
    while (bus_if.ready !== 1'b1 && stall < 20) begin
      if (stall > 0) begin
        chk({tag, "_addr"}, 32'(sram_addr), exp_addr);
        chk({tag, "_we_n"}, {31'd0, sram_we_n}, {31'd0, ~wr});
        chk({tag, "_dq"}, sram_dq, exp_dq);
      end
      stall++;
      next_cycle();
    end
    chk({tag, "_stall"}, 32'(stall), 32'd5);
    chk({tag, "_done_ready"}, {31'd0, bus_if.ready}, 32'd1);
    bus_if.rd_en = 1'b0;
    bus_if.wr_en = 1'b0;
  endtask

  initial begin
    n_tests           = 0;
    n_fail            = 0;
    rst               = 1'b0;
    model_init        = 1'b1;
    bus_if.rd_en      = 1'b0;
    bus_if.wr_en      = 1'b0;
    bus_if.address    = 32'd0;
    bus_if.write_data = 32'd0;

    // Reset with no requests
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b1;
    model_init = 1'b0;
    #1;
    chk("rst_ready", {31'd0, bus_if.ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_dq_z", sram_dq, 32'hA0A0A0A0);
    chk("rst_rdata", bus_if.read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'h1FF00);

    // Single write to byte 1032 -> word 2
    next_cycle();
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd2, 32'hDEADBEEF, "wr1");
    chk("wr1_rdata", bus_if.read_data, 32'd0);

    // Read-back; DONE must ignore the still-asserted request
    next_cycle();
    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'd2, 32'hDEADBEEF, "rd1");
    chk("rd1_rdata", bus_if.read_data, 32'hDEADBEEF);
    next_cycle();
    chk("rd1_hold", bus_if.read_data, 32'hDEADBEEF);
    chk("rd1_idle_ready", {31'd0, bus_if.ready}, 32'd1);
    chk("rd1_idle_we_n", {31'd0, sram_we_n}, 32'd1);

    // Simultaneous rd/wr is a write
    next_cycle();
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, 32'd0, 32'h12345678, "both");
    chk("both_rdata", bus_if.read_data, 32'hDEADBEEF);

    // Reset during ACCESS cycle 2 of a write
    next_cycle();
    bus_if.wr_en      = 1'b1;
    bus_if.address    = 32'd1032;
    bus_if.write_data = 32'h55AA55AA;
    next_cycle();
    next_cycle();
    chk("mid_we_n_pre", {31'd0, sram_we_n}, 32'd0);
    rst          = 1'b0;
    bus_if.wr_en = 1'b0;
    next_cycle();
    chk("mid_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("mid_dq_z", sram_dq, 32'h12345678);
    chk("mid_addr", 32'(sram_addr), 32'h1FF00);
    chk("mid_rdata", bus_if.read_data, 32'd0);
    chk("mid_ready", {31'd0, bus_if.ready}, 32'd1);
    rst = 1'b1;
    next_cycle();
    access(1'b1, 1'b0, 32'd1032, 32'd0, 32'd2, 32'h55AA55AA, "rd2");
    chk("rd2_rdata", bus_if.read_data, 32'h55AA55AA);

    // Back-to-back with address wrap in both directions
    next_cycle();
    access(1'b1, 1'b0, 32'd1020, 32'd0, 32'h1FFFF, 32'hD3D3D3D3, "wrap_rd");
    chk("wrap_rd_rdata", bus_if.read_data, 32'hD3D3D3D3);
    next_cycle();
    chk("gap_ready", {31'd0, bus_if.ready}, 32'd1);
    access(1'b0, 1'b1, 32'h000803FC, 32'hCAFEF00D, 32'h1FFFF, 32'hCAFEF00D, "wrap_wr");
    chk("wrap_wr_rdata", bus_if.read_data, 32'hD3D3D3D3);
    next_cycle();
    chk("end_ready", {31'd0, bus_if.ready}, 32'd1);
    chk("end_dq_z", sram_dq, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
